// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin arbiter feeding one registered output slot.
// Define RR_ARB_MUX_PRIO_EN to add a prio_mode input that selects fixed priority.
module rr_arb_mux #(
    parameter int N  = 4,
    parameter int W  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef RR_ARB_MUX_PRIO_EN
    input  logic           prio_mode,
`endif
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    // Handshake: a word moves on an edge where valid && ready are both high; valid never
    // waits on ready, and in_ready depends on in_valid, out_valid and out_ready only.
    logic [SW-1:0] ptr;
    logic [SW-1:0] start;
    logic [SW-1:0] gidx;
    logic [SW-1:0] sidx;
    logic [SW-1:0] ptr_nxt;
    logic [SW:0]   sum;
    logic [W-1:0]  gdata;
    logic          load;
    logic          found;
    logic          take;
    logic          fixed;

`ifdef RR_ARB_MUX_PRIO_EN
    assign fixed = prio_mode;
`else
    assign fixed = 1'b0;
`endif

    assign load  = !out_valid || out_ready;
    assign start = fixed ? '0 : ptr;
    assign take  = found && load;

    // Walk the channels from farthest to nearest so the nearest requester wins.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        gdata = '0;
        sum   = '0;
        sidx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, start} + (SW + 1)'(k);
            if (sum >= (SW + 1)'(N)) begin
                sum = sum - (SW + 1)'(N);
            end
            sidx = sum[SW-1:0];
            if (in_valid[sidx]) begin
                found = 1'b1;
                gidx  = sidx;
                gdata = in_data[int'(sidx) * W +: W];
            end
        end
    end

    assign ptr_nxt = (gidx == SW'(N - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        in_ready = '0;
        if (take && rst_n) begin
            in_ready[gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                out_sel   <= gidx;
                if (!fixed) begin
                    ptr <= ptr_nxt;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Testbench for rr_arb_mux: directed scenarios plus random traffic against a behavioural model.
module tb_rr_arb_mux;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int SW = 2;
    localparam logic [N*W-1:0] BASE = {4'hF, 4'hE, 4'hD, 4'hC};

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           prio_mode = 1'b0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic           out_ready = 1'b0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;

    always #5 clk = ~clk;

    rr_arb_mux #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef RR_ARB_MUX_PRIO_EN
        .prio_mode (prio_mode),
`endif
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: next-in-line pointer plus the contents of the output slot.
    int           m_ptr = 0;
    logic         m_ov = 1'b0;
    logic [W-1:0] m_od = '0;
    logic [SW-1:0] m_os = '0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int first);
        for (int k = 0; k < N; k++) begin
            if (v[(first + k) % N]) return (first + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_ov  = 1'b0;
        m_od  = '0;
        m_os  = '0;
        exp_q.delete();
    endtask

    // One clock: drive inputs at negedge, check against the model, advance model, pass posedge.
    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
        int           g;
        logic         ld;
        logic [N-1:0] one;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        one = 1;
        ld = !m_ov || r;
        g = ld ? pick(v, prio_mode ? 0 : m_ptr) : -1;
        exp_rdy = (g >= 0) ? (one << g) : '0;
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, m_ov);
        check("out_data", out_data, m_od);
        check("out_sel", out_sel, m_os);
        if (m_ov && r) begin
            check("drain_q_size", exp_q.size(), 1);
            if (exp_q.size() > 0) check("drain_data", out_data, exp_q.pop_front());
        end
        if (ld) begin
            if (g >= 0) begin
                m_ov = 1'b1;
                m_od = d[g*W +: W];
                m_os = SW'(g);
                exp_q.push_back(d[g*W +: W]);
                if (!prio_mode) m_ptr = (g + 1) % N;
            end else begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with requests present: everything zero, nothing accepted.
        in_valid = '1;
        in_data  = BASE;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_in_ready", in_ready, 0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        in_valid = '0;

        // All channels requesting: strict rotation 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, BASE, 1'b1);
            check("rr_sel", out_sel, i % 4);
            check("rr_data", out_data, 12 + (i % 4));
        end

        // Single requester on channel 2, then everyone: channel 3 is next.
        for (int i = 0; i < 4; i++) cycle(4'b0100, BASE, 1'b1);
        check("solo_sel", out_sel, 2);
        check("solo_data", out_data, 4'hE);
        cycle(4'b1111, BASE, 1'b1);
        check("after_solo_sel", out_sel, 3);

        // Stall for three cycles with changing inputs, then resume from the stored pointer.
        for (int i = 0; i < 3; i++) cycle(4'($urandom), $urandom, 1'b0);
        check("stall_sel", out_sel, 3);
        check("stall_data", out_data, 4'hF);
        cycle(4'b1111, BASE, 1'b1);
        check("resume_sel", out_sel, 0);

        // Requests vanish: slot empties, data holds.
        cycle(4'b0000, BASE, 1'b1);
        check("drop_valid", out_valid, 0);
        check("drop_data", out_data, 4'hC);

        // Refill, then reset between edges; channel 1 wins first after release.
        cycle(4'b1111, BASE, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_sel", out_sel, 0);
        check("mid_rst_ready", in_ready, 0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        in_valid = '0;
        cycle(4'b1010, BASE, 1'b1);
        check("post_rst_sel", out_sel, 1);
        check("post_rst_data", out_data, 4'hD);

`ifdef RR_ARB_MUX_PRIO_EN
        prio_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(4'b1111, BASE, 1'b1);
            check("prio_sel_all", out_sel, 0);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1100, BASE, 1'b1);
            check("prio_sel_hi", out_sel, 2);
        end
        prio_mode = 1'b0;
`endif

        // Random traffic and backpressure.
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
